// File: rtl/issue_queue_free_list_if.sv
// Dispatch/scheduler-facing bundle of the issue-queue free list.
// The master modport is the dispatch/recovery side and the slave modport is the allocator.
interface issue_queue_free_list_if #(
    parameter int ENTRY_NUM     = 16,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 2
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);

    logic [ALLOC_WIDTH-1:0]              allocReq;
    logic                                allocGrant;
    logic [ALLOC_WIDTH-1:0][IDX_W-1:0]   allocPtr;
    logic [RELEASE_WIDTH-1:0]            releaseValid;
    logic [RELEASE_WIDTH-1:0][IDX_W-1:0] releasePtr;
    logic [CNT_W-1:0]                    freeCount;
    logic                                noFreeEntry;
    logic                                error;

    modport master (
        output allocReq, releaseValid, releasePtr,
        input  allocGrant, allocPtr, freeCount, noFreeEntry, error
    );

    modport slave (
        input  allocReq, releaseValid, releasePtr,
        output allocGrant, allocPtr, freeCount, noFreeEntry, error
    );
endinterface

// File: rtl/issue_queue_free_list.sv
// Circular FIFO of free issue-queue entry indices with a free counter.
// Defining RSD_IQ_FREELIST_CHECK_EN adds an allocated bitmap and a sticky protocol error flag.
module issue_queue_free_list #(
    parameter int ENTRY_NUM     = 16,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    issue_queue_free_list_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);

    logic [IDX_W-1:0]         list [ENTRY_NUM];
    logic [IDX_W-1:0]         head;
    logic [IDX_W-1:0]         tail;
    logic [CNT_W-1:0]         count;

    logic [CNT_W-1:0]         alloc_n;
    logic [CNT_W-1:0]         rel_n;
    logic                     grant;
    logic [RELEASE_WIDTH-1:0] rel_ok;
    logic [IDX_W-1:0]         rel_slot [RELEASE_WIDTH];

`ifdef RSD_IQ_FREELIST_CHECK_EN
    logic [ENTRY_NUM-1:0]     allocated;
    logic [ENTRY_NUM-1:0]     set_mask;
    logic [ENTRY_NUM-1:0]     clr_mask;
    logic                     rel_err;
    logic                     req_err;
    logic                     error_q;
`endif

    always_comb begin
        alloc_n = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_n = alloc_n + CNT_W'(bus.allocReq[i]);
        end
    end

    // All-or-nothing grant against the pre-update count, so same-cycle releases never help.
    assign grant          = (alloc_n != '0) && (count >= alloc_n);
    assign bus.allocGrant = grant;
    assign bus.freeCount  = count;
    assign bus.noFreeEntry = (count == '0);

    always_comb begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            bus.allocPtr[i] = list[head + IDX_W'(i)];
        end
    end

    // Accepted release lanes are compacted onto consecutive slots starting at tail.
    always_comb begin
        rel_n  = '0;
        rel_ok = '0;
`ifdef RSD_IQ_FREELIST_CHECK_EN
        clr_mask = '0;
        rel_err  = 1'b0;
`endif
        for (int k = 0; k < RELEASE_WIDTH; k++) begin
            rel_slot[k] = tail + IDX_W'(rel_n);
            if (bus.releaseValid[k]) begin
`ifdef RSD_IQ_FREELIST_CHECK_EN
                if (allocated[bus.releasePtr[k]] && !clr_mask[bus.releasePtr[k]] &&
                    (int'(count) + int'(rel_n) < ENTRY_NUM)) begin
                    rel_ok[k] = 1'b1;
                    clr_mask[bus.releasePtr[k]] = 1'b1;
                end else begin
                    rel_err = 1'b1;
                end
`else
                rel_ok[k] = 1'b1;
`endif
            end
            if (rel_ok[k]) begin
                rel_n = rel_n + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                list[i] <= IDX_W'(i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(ENTRY_NUM);
        end else begin
            for (int k = 0; k < RELEASE_WIDTH; k++) begin
                if (rel_ok[k]) begin
                    list[rel_slot[k]] <= bus.releasePtr[k];
                end
            end
            if (grant) begin
                head <= head + IDX_W'(alloc_n);
            end
            tail  <= tail + IDX_W'(rel_n);
            count <= count - (grant ? alloc_n : '0) + rel_n;
        end
    end

`ifdef RSD_IQ_FREELIST_CHECK_EN
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (grant && bus.allocReq[i]) begin
                set_mask[list[head + IDX_W'(i)]] = 1'b1;
            end
        end
    end

    // A prefix-contiguous request has the form 0..01..1, so x & (x+1) is zero.
    assign req_err   = (bus.allocReq & (bus.allocReq + ALLOC_WIDTH'(1))) != '0;
    assign bus.error = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            allocated <= '0;
            error_q   <= 1'b0;
        end else begin
            allocated <= (allocated | set_mask) & ~clr_mask;
            if (rel_err || req_err) begin
                error_q <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && (rel_err || req_err)) begin
            $error("issue_queue_free_list: protocol error (rel_err=%0b req_err=%0b)", rel_err, req_err);
        end
    end
`endif
`else
    assign bus.error = 1'b0;
`endif
endmodule
